tx_huge_pages_regs: RTL and testbench

TX_HUGE_PAGES_REGS -- requirements
Module: tx_huge_pages_regs

---
 rtl/tx_huge_pages_regs_pkg.sv | 37 +++
 rtl/tx_huge_pages_regs_status_cell.sv | 28 ++
 rtl/tx_huge_pages_regs.sv | 193 +++++++++++++++++++
 tb/tb_tx_huge_pages_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_huge_pages_regs_pkg.sv
// Shared constants for the TX huge-page register block: FSM encoding,
// TLP fmt/type codes, register DW offsets and the page-count ceiling.
package tx_huge_pages_regs_pkg;

  localparam int MAX_PAGES  = 8;
  localparam int PAGE_IDX_W = $clog2(MAX_PAGES);

  // Receive FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // fmt/type field trn_rd[62:56] for memory writes
  localparam logic [6:0] FMT_MWR32 = 7'b10_00000;
  localparam logic [6:0] FMT_MWR64 = 7'b11_00000;

  // DW offsets: 0/1 completion address lo/hi; page i at 16+4i (addr lo),
  // 17+4i (addr hi), 18+4i (qwords + unlock). 64-bit registers are only
  // written as a whole, starting at their low DW.
  localparam logic [5:0] OFF_CBA_LO    = 6'd0;
  localparam logic [5:0] OFF_PAGE_BASE = 6'd16;
  localparam logic [1:0] SUB_ADDR_LO   = 2'd0;
  localparam logic [1:0] SUB_QWORDS    = 2'd2;

  typedef enum logic [1:0] {
    TGT_CBA  = 2'd0,
    TGT_ADDR = 2'd1,
    TGT_QW   = 2'd2
  } tgt_kind_e;

  // Payload DWs arrive byte-reversed relative to register layout
  function automatic logic [31:0] bswap32(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/tx_huge_pages_regs_status_cell.sv
// Per-page armed flag: set by an unlock pulse, cleared by the consumer's
// free strobe. Set wins so a re-arm racing a free is never lost.
module hp_status_cell (
  input  logic trn_clk,
  input  logic reset_n,
  input  logic unlock,
  input  logic free,
  output logic status
);

  logic status_q, status_d;

  // next-state: set has priority over clear
  always_comb begin
    status_d = status_q;
    if (unlock)    status_d = 1'b1;
    else if (free) status_d = 1'b0;
  end

  // armed flag register
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) status_q <= 1'b0;
    else          status_q <= status_d;
  end

  assign status = status_q;

endmodule

// File: rtl/tx_huge_pages_regs.sv
// TRN RX snooper that decodes 1-/2-DW memory writes to a BAR and updates
// the huge-page descriptor registers and the completion buffer address.
module tx_huge_pages_regs
  import tx_huge_pages_regs_pkg::*;
#(
  parameter int NUM_PAGES = 2,
  parameter int BAR_IDX   = 2
) (
  input  logic                    trn_clk,
  input  logic                    reset_n,
  input  logic [63:0]             trn_rd,
  input  logic [7:0]              trn_rrem_n,
  input  logic                    trn_rsof_n,
  input  logic                    trn_reof_n,
  input  logic                    trn_rsrc_rdy_n,
  input  logic                    trn_rsrc_dsc_n,
  input  logic                    trn_rdst_rdy_n,
  input  logic [6:0]              trn_rbar_hit_n,
  output logic [64*NUM_PAGES-1:0] huge_page_addr,
  output logic [32*NUM_PAGES-1:0] huge_page_qwords,
  output logic [NUM_PAGES-1:0]    huge_page_status,
  input  logic [NUM_PAGES-1:0]    huge_page_free,
  output logic [63:0]             completed_buffer_address,
  output logic [15:0]             ignored_wr_cnt
);

  logic beat, sof, eof, dsc, hit, is_mwr;
  assign beat   = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof    = ~trn_rsof_n;
  assign eof    = ~trn_reof_n;
  assign dsc    = ~trn_rsrc_dsc_n;
  assign hit    = ~trn_rbar_hit_n[BAR_IDX];
  assign is_mwr = (trn_rd[62:56] == FMT_MWR32) || (trn_rd[62:56] == FMT_MWR64);

  // Remainder and most header fields carry nothing this block needs
  logic unused_ok;
  assign unused_ok = ^{trn_rrem_n, trn_rd, trn_rbar_hit_n};

  logic [1:0]                      state_q, state_d;
  logic                            is64_q, is64_d;
  logic [9:0]                      len_q, len_d;
  tgt_kind_e                       kind_q, kind_d;
  logic [PAGE_IDX_W-1:0]           page_q, page_d;
  logic [31:0]                     shadow_q, shadow_d;
  logic [63:0]                     cba_q, cba_d;
  logic [NUM_PAGES-1:0][63:0]      addr_q, addr_d;
  logic [NUM_PAGES-1:0][31:0]      qw_q, qw_d;
  logic [NUM_PAGES-1:0]            unlock_q, unlock_d;
  logic [15:0]                     ign_q, ign_d;

  // Beat-2 address decode: offset position depends on header size
  logic [5:0]            off, rel;
  logic                  dec_ok;
  tgt_kind_e             dec_kind;
  logic [PAGE_IDX_W-1:0] dec_page;

  // offset -> register target, with the length each target demands
  always_comb begin
    off      = is64_q ? trn_rd[7:2] : trn_rd[39:34];
    rel      = off - OFF_PAGE_BASE;
    dec_ok   = 1'b0;
    dec_kind = TGT_CBA;
    dec_page = rel[4:2];
    if (off == OFF_CBA_LO) begin
      dec_ok = (len_q == 10'd2);
    end else if (off >= OFF_PAGE_BASE && !rel[5] && int'(rel[4:2]) < NUM_PAGES) begin
      if (rel[1:0] == SUB_ADDR_LO) begin
        dec_kind = TGT_ADDR;
        dec_ok   = (len_q == 10'd2);
      end else if (rel[1:0] == SUB_QWORDS) begin
        dec_kind = TGT_QW;
        dec_ok   = (len_q == 10'd1);
      end
    end
  end

  // Beat-3 payload: MWr64 carries both DWs here, MWr32 only DW1
  logic [31:0] lo_dw, hi_dw;
  assign lo_dw = is64_q ? bswap32(trn_rd[63:32]) : shadow_q;
  assign hi_dw = is64_q ? bswap32(trn_rd[31:0])  : bswap32(trn_rd[63:32]);

  // TLP walker: abort beats first, then new-TLP starts, then per-state work
  always_comb begin
    state_d  = state_q;
    is64_d   = is64_q;
    len_d    = len_q;
    kind_d   = kind_q;
    page_d   = page_q;
    shadow_d = shadow_q;
    cba_d    = cba_q;
    addr_d   = addr_q;
    qw_d     = qw_q;
    unlock_d = '0;
    ign_d    = ign_q;
    if (beat) begin
      if (dsc) begin
        state_d  = ST_IDLE;
        shadow_d = '0;
      end else if (sof) begin
        is64_d = trn_rd[61];
        len_d  = trn_rd[41:32];
        if (eof)                state_d = ST_IDLE;
        else if (hit && is_mwr) state_d = ST_HDR;
        else                    state_d = ST_DRAIN;
      end else begin
        case (state_q)
          ST_HDR: begin
            kind_d = dec_kind;
            page_d = dec_page;
            if (!dec_ok) begin
              if (ign_q != 16'hFFFF) ign_d = ign_q + 16'd1;
              state_d = eof ? ST_IDLE : ST_DRAIN;
            end else if (!is64_q && dec_kind == TGT_QW) begin
              // 3DW qwords write: whole payload is already here
              for (int i = 0; i < NUM_PAGES; i++) begin
                if (dec_page == PAGE_IDX_W'(i)) begin
                  qw_d[i]     = bswap32(trn_rd[31:0]);
                  unlock_d[i] = 1'b1;
                end
              end
              state_d = eof ? ST_IDLE : ST_DRAIN;
            end else begin
              if (!is64_q) shadow_d = bswap32(trn_rd[31:0]);
              // eof here means the payload is truncated: drop it
              state_d = eof ? ST_IDLE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (kind_q == TGT_CBA) cba_d = {hi_dw, lo_dw};
            for (int i = 0; i < NUM_PAGES; i++) begin
              if (page_q == PAGE_IDX_W'(i)) begin
                if (kind_q == TGT_ADDR) begin
                  addr_d[i] = {hi_dw, lo_dw};
                end else if (kind_q == TGT_QW) begin
                  qw_d[i]     = lo_dw;
                  unlock_d[i] = 1'b1;
                end
              end
            end
            state_d = eof ? ST_IDLE : ST_DRAIN;
          end
          ST_DRAIN: if (eof) state_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  // register file and walker state
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      is64_q   <= 1'b0;
      len_q    <= '0;
      kind_q   <= TGT_CBA;
      page_q   <= '0;
      shadow_q <= '0;
      cba_q    <= '0;
      addr_q   <= '0;
      qw_q     <= '0;
      unlock_q <= '0;
      ign_q    <= '0;
    end else begin
      state_q  <= state_d;
      is64_q   <= is64_d;
      len_q    <= len_d;
      kind_q   <= kind_d;
      page_q   <= page_d;
      shadow_q <= shadow_d;
      cba_q    <= cba_d;
      addr_q   <= addr_d;
      qw_q     <= qw_d;
      unlock_q <= unlock_d;
      ign_q    <= ign_d;
    end
  end

  for (genvar g = 0; g < NUM_PAGES; g++) begin : g_page
    hp_status_cell u_status (
      .trn_clk (trn_clk),
      .reset_n (reset_n),
      .unlock  (unlock_q[g]),
      .free    (huge_page_free[g]),
      .status  (huge_page_status[g])
    );
  end

  assign huge_page_addr           = addr_q;
  assign huge_page_qwords         = qw_q;
  assign completed_buffer_address = cba_q;
  assign ignored_wr_cnt           = ign_q;

endmodule

// File: tb/tb_tx_huge_pages_regs.sv
// Directed bench for tx_huge_pages_regs with four pages on BAR 2.
module tb_tx_huge_pages_regs;

  localparam int NP = 4;
  localparam logic [6:0] F32 = 7'b10_00000;
  localparam logic [6:0] F64 = 7'b11_00000;
  localparam logic [6:0] FRD = 7'b00_00000;

  logic               trn_clk = 1'b0;
  logic               reset_n;
  logic [63:0]        trn_rd;
  logic [7:0]         trn_rrem_n;
  logic               trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
  logic [6:0]         trn_rbar_hit_n;
  logic [64*NP-1:0]   huge_page_addr;
  logic [32*NP-1:0]   huge_page_qwords;
  logic [NP-1:0]      huge_page_status;
  logic [NP-1:0]      huge_page_free;
  logic [63:0]        completed_buffer_address;
  logic [15:0]        ignored_wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 trn_clk = ~trn_clk;

  tx_huge_pages_regs #(.NUM_PAGES(NP), .BAR_IDX(2)) dut (
    .trn_clk                  (trn_clk),
    .reset_n                  (reset_n),
    .trn_rd                   (trn_rd),
    .trn_rrem_n               (trn_rrem_n),
    .trn_rsof_n               (trn_rsof_n),
    .trn_reof_n               (trn_reof_n),
    .trn_rsrc_rdy_n           (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n           (trn_rsrc_dsc_n),
    .trn_rdst_rdy_n           (trn_rdst_rdy_n),
    .trn_rbar_hit_n           (trn_rbar_hit_n),
    .huge_page_addr           (huge_page_addr),
    .huge_page_qwords         (huge_page_qwords),
    .huge_page_status         (huge_page_status),
    .huge_page_free           (huge_page_free),
    .completed_buffer_address (completed_buffer_address),
    .ignored_wr_cnt           (ignored_wr_cnt)
  );

  function automatic logic [63:0] hdr(input logic [6:0] fmt, input int len);
    return {1'b0, fmt, 14'h0, 10'(len), 32'h0000_00FF};
  endfunction

  function automatic logic [63:0] a32(input int off, input logic [31:0] dw);
    return {32'(off * 4), dw};
  endfunction

  function automatic logic [63:0] a64(input int off);
    return {32'h0, 32'(off * 4)};
  endfunction

  task automatic send(input logic [63:0] d, input logic sof, input logic eof, input logic dsc);
    trn_rd = d; trn_rsof_n = ~sof; trn_reof_n = ~eof; trn_rsrc_dsc_n = ~dsc; trn_rsrc_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    trn_rd = '0; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1; trn_rsrc_rdy_n = 1'b1;
  endtask

  // Every strobe asserted but the sink not ready: must be ignored entirely
  task automatic stall();
    trn_rd = 64'hFFFF_FFFF_FFFF_FFFF; trn_rsof_n = 1'b0; trn_reof_n = 1'b0; trn_rsrc_dsc_n = 1'b0;
    trn_rsrc_rdy_n = 1'b0; trn_rdst_rdy_n = 1'b1;
    @(posedge trn_clk); #1;
    trn_rd = '0; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rsrc_rdy_n = 1'b1; trn_rdst_rdy_n = 1'b0;
  endtask

  task automatic idle();
    @(posedge trn_clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (huge_page_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", huge_page_addr); end
    n_checks++; if (huge_page_qwords !== '0) begin n_fail++; $display("FAIL reset_qwords: got %h expected 0", huge_page_qwords); end
    n_checks++; if (huge_page_status !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b expected 0000", huge_page_status); end
    n_checks++; if (completed_buffer_address !== 64'h0) begin n_fail++; $display("FAIL reset_cba: got %h expected 0", completed_buffer_address); end
    n_checks++; if (ignored_wr_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ignored: got %h expected 0", ignored_wr_cnt); end
  endtask

  task automatic test_mwr32_addr();
    send(hdr(F32, 2), 1, 0, 0);
    stall();
    send(a32(16, 32'h78563412), 0, 0, 0);
    n_checks++; if (huge_page_addr[63:0] !== 64'h0) begin n_fail++; $display("FAIL addr32_half: got %h expected 0", huge_page_addr[63:0]); end
    stall();
    send({32'h00F0DEBC, 32'h0}, 0, 1, 0);
    n_checks++; if (huge_page_addr[63:0] !== 64'hBCDEF000_12345678) begin n_fail++; $display("FAIL addr32_page0: got %h expected bcdef00012345678", huge_page_addr[63:0]); end
    n_checks++; if (huge_page_addr[255:64] !== '0) begin n_fail++; $display("FAIL addr32_others: got %h expected 0", huge_page_addr[255:64]); end
  endtask

  task automatic test_mwr64_qwords();
    send(hdr(F64, 1), 1, 0, 0);
    send(a64(30), 0, 0, 0);
    send({32'h00010000, 32'h0}, 0, 1, 0);
    n_checks++; if (huge_page_qwords[127:96] !== 32'h00000100) begin n_fail++; $display("FAIL qw64_page3: got %h expected 00000100", huge_page_qwords[127:96]); end
    n_checks++; if (huge_page_status !== 4'b0000) begin n_fail++; $display("FAIL qw64_status_early: got %b expected 0000", huge_page_status); end
    idle();
    n_checks++; if (huge_page_status !== 4'b1000) begin n_fail++; $display("FAIL qw64_status_set: got %b expected 1000", huge_page_status); end
    huge_page_free = 4'b1000;
    idle();
    n_checks++; if (huge_page_status !== 4'b0000) begin n_fail++; $display("FAIL qw64_free: got %b expected 0000", huge_page_status); end
    huge_page_free = 4'b0000;
  endtask

  task automatic test_unlock_free();
    huge_page_free = 4'b0010;
    send(hdr(F32, 1), 1, 0, 0);
    send(a32(22, 32'h44332211), 0, 1, 0);
    n_checks++; if (huge_page_qwords[63:32] !== 32'h11223344) begin n_fail++; $display("FAIL uf_qwords1: got %h expected 11223344", huge_page_qwords[63:32]); end
    idle();
    n_checks++; if (huge_page_status !== 4'b0010) begin n_fail++; $display("FAIL uf_set_wins: got %b expected 0010", huge_page_status); end
    idle();
    n_checks++; if (huge_page_status !== 4'b0000) begin n_fail++; $display("FAIL uf_cleared: got %b expected 0000", huge_page_status); end
    huge_page_free = 4'b0000;
  endtask

  task automatic test_discard();
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(0, 32'hAABBCCDD), 0, 0, 0);
    send({32'h11223344, 32'h0}, 0, 1, 1);
    n_checks++; if (completed_buffer_address !== 64'h0) begin n_fail++; $display("FAIL dsc_cba: got %h expected 0", completed_buffer_address); end
    // a stray data beat would commit if the walker were still in DATA
    send({32'h55667788, 32'h0}, 0, 1, 0);
    n_checks++; if (completed_buffer_address !== 64'h0) begin n_fail++; $display("FAIL dsc_idle: got %h expected 0", completed_buffer_address); end
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(0, 32'h67452301), 0, 0, 0);
    send({32'hEFCDAB89, 32'h0}, 0, 1, 0);
    n_checks++; if (completed_buffer_address !== 64'h89ABCDEF_01234567) begin n_fail++; $display("FAIL cba_write: got %h expected 89abcdef01234567", completed_buffer_address); end
    n_checks++; if (ignored_wr_cnt !== 16'd0) begin n_fail++; $display("FAIL dsc_ignored: got %0d expected 0", ignored_wr_cnt); end
  endtask

  task automatic test_ignored();
    send(hdr(F32, 3), 1, 0, 0);
    send(a32(16, 32'h11111111), 0, 0, 0);
    stall();
    send({32'h22222222, 32'h33333333}, 0, 0, 0);
    send({32'h44444444, 32'h0}, 0, 1, 0);
    n_checks++; if (ignored_wr_cnt !== 16'd1) begin n_fail++; $display("FAIL ign_len3: got %0d expected 1", ignored_wr_cnt); end
    n_checks++; if (huge_page_addr[63:0] !== 64'hBCDEF000_12345678) begin n_fail++; $display("FAIL ign_len3_addr: got %h expected bcdef00012345678", huge_page_addr[63:0]); end
    send(hdr(F32, 1), 1, 0, 0);
    send(a32(5, 32'h00000005), 0, 1, 0);
    n_checks++; if (ignored_wr_cnt !== 16'd2) begin n_fail++; $display("FAIL ign_off5: got %0d expected 2", ignored_wr_cnt); end
    // page 4 does not exist with four pages
    send(hdr(F64, 2), 1, 0, 0);
    send(a64(32), 0, 0, 0);
    send({32'h01020304, 32'h05060708}, 0, 1, 0);
    n_checks++; if (ignored_wr_cnt !== 16'd3) begin n_fail++; $display("FAIL ign_page4: got %0d expected 3", ignored_wr_cnt); end
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(18, 32'h99999999), 0, 0, 0);
    send({32'h88888888, 32'h0}, 0, 1, 0);
    n_checks++; if (ignored_wr_cnt !== 16'd4) begin n_fail++; $display("FAIL ign_qw_len2: got %0d expected 4", ignored_wr_cnt); end
    n_checks++; if (huge_page_qwords[31:0] !== 32'h0) begin n_fail++; $display("FAIL ign_qw_len2_val: got %h expected 0", huge_page_qwords[31:0]); end
    trn_rbar_hit_n = 7'b0000100;
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(0, 32'h12121212), 0, 0, 0);
    send({32'h34343434, 32'h0}, 0, 1, 0);
    trn_rbar_hit_n = 7'b1111011;
    send(hdr(FRD, 2), 1, 0, 0);
    send(a32(0, 32'h0), 0, 1, 0);
    n_checks++; if (ignored_wr_cnt !== 16'd4) begin n_fail++; $display("FAIL ign_drained: got %0d expected 4", ignored_wr_cnt); end
    n_checks++; if (completed_buffer_address !== 64'h89ABCDEF_01234567) begin n_fail++; $display("FAIL ign_drained_cba: got %h expected 89abcdef01234567", completed_buffer_address); end
  endtask

  task automatic test_back_to_back();
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(20, 32'hDEADBEEF), 0, 0, 0);
    // new sof while the first TLP still waits for its DW1
    send(hdr(F64, 2), 1, 0, 0);
    send(a64(24), 0, 0, 0);
    send({32'h04030201, 32'h08070605}, 0, 1, 0);
    send(hdr(F32, 1), 1, 0, 0);
    send(a32(18, 32'hEFBEADDE), 0, 1, 0);
    n_checks++; if (huge_page_addr[191:128] !== 64'h05060708_01020304) begin n_fail++; $display("FAIL b2b_addr2: got %h expected 0506070801020304", huge_page_addr[191:128]); end
    n_checks++; if (huge_page_addr[127:64] !== 64'h0) begin n_fail++; $display("FAIL b2b_addr1: got %h expected 0", huge_page_addr[127:64]); end
    n_checks++; if (huge_page_qwords[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_qw0: got %h expected deadbeef", huge_page_qwords[31:0]); end
    idle();
    n_checks++; if (huge_page_status !== 4'b0001) begin n_fail++; $display("FAIL b2b_status: got %b expected 0001", huge_page_status); end
  endtask

  task automatic test_reset_mid();
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(16, 32'h01010101), 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (huge_page_addr !== '0) begin n_fail++; $display("FAIL arst_addr: got %h expected 0", huge_page_addr); end
    n_checks++; if (completed_buffer_address !== 64'h0) begin n_fail++; $display("FAIL arst_cba: got %h expected 0", completed_buffer_address); end
    n_checks++; if (huge_page_qwords !== '0) begin n_fail++; $display("FAIL arst_qwords: got %h expected 0", huge_page_qwords); end
    n_checks++; if (huge_page_status !== 4'b0000) begin n_fail++; $display("FAIL arst_status: got %b expected 0000", huge_page_status); end
    n_checks++; if (ignored_wr_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_ignored: got %h expected 0", ignored_wr_cnt); end
    idle();
    reset_n = 1'b1;
    send({32'h02020202, 32'h0}, 0, 1, 0);
    n_checks++; if (huge_page_addr[63:0] !== 64'h0) begin n_fail++; $display("FAIL arst_stray: got %h expected 0", huge_page_addr[63:0]); end
    send(hdr(F32, 2), 1, 0, 0);
    send(a32(16, 32'h78563412), 0, 0, 0);
    send({32'h00F0DEBC, 32'h0}, 0, 1, 0);
    n_checks++; if (huge_page_addr[63:0] !== 64'hBCDEF000_12345678) begin n_fail++; $display("FAIL arst_after: got %h expected bcdef00012345678", huge_page_addr[63:0]); end
  endtask

  initial begin
    reset_n        = 1'b0;
    trn_rd         = '0;
    trn_rrem_n     = 8'h00;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    trn_rbar_hit_n = 7'b1111011;
    huge_page_free = '0;
    repeat (2) @(posedge trn_clk);
    #1 reset_n = 1'b1;
    idle();
    test_reset();
    test_mwr32_addr();
    test_mwr64_qwords();
    test_unlock_free();
    test_discard();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
